// File: rtl/led_status_pkg.sv
// led_status_pkg
// Shared definitions for the front-panel LED / status-pin controller:
// per-LED display modes, the error flash step mask and a helper that turns
// the top three flash counter bits into the error pattern level.
package led_status_pkg;

    typedef enum logic [1:0] {
        LED_MODE_DIRECT  = 2'd0,
        LED_MODE_STRETCH = 2'd1,
        LED_MODE_BLINK   = 2'd2,
        LED_MODE_OFF     = 2'd3
    } led_mode_e;

    // Eight equal steps per flash period; lit on steps 0, 2 and 4 gives
    // three short blinks followed by a longer pause.
    localparam logic [7:0] FLASH_STEP_MASK = 8'b0001_0101;

    function automatic logic flash_pattern(input logic [2:0] step);
        return FLASH_STEP_MASK[step];
    endfunction

endpackage

// File: rtl/led_stretch.sv
// led_stretch
// Per-LED pulse stretcher. A trigger (one-cycle rise) loads a down-counter
// with all ones; the output stays on while the counter is non-zero and also
// during the trigger cycle itself, so an isolated trigger lights the LED for
// exactly 2^pBITS cycles. Retriggers reload rather than accumulate.
// Ports:
//   usb_clk   clock
//   reset_i   asynchronous active-high reset
//   I_trig    one-cycle rise event from the selected source
//   I_enable  channel is in STRETCH mode; low clears the counter
//   O_on      stretched LED level (combinational, registered by the parent)
module led_stretch #(
    parameter int pBITS = 20
) (
    input  logic usb_clk,
    input  logic reset_i,
    input  logic I_trig,
    input  logic I_enable,
    output logic O_on
);

    logic [pBITS-1:0] cnt;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (!I_enable) begin
            cnt <= '0;
        end else if (I_trig) begin
            cnt <= '1;
        end else if (cnt != '0) begin
            cnt <= cnt - pBITS'(1);
        end
    end

    assign O_on = I_enable & (I_trig | (cnt != '0));

endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl
// Front-panel LED / status-pin controller. Each LED picks one synchronised
// status source and shows it directly, stretched, blinking or not at all.
// A latched error flag can override every LED with a three-blink pattern.
// Ports:
//   usb_clk          sole clock
//   reset_i          asynchronous active-high reset
//   I_src            status levels/events, may be asynchronous
//   I_sel            per-LED source index, LED n at [n*pSELW +: pSELW]
//   I_mode           per-LED mode, LED n at [n*2 +: 2]
//   I_error          error level, asynchronous
//   I_clear_error    single-cycle clear of the latched error
//   I_error_en       allows the error pattern to override the LEDs
//   O_led            registered LED drive
//   O_error_latched  latched error flag
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int pLEDS         = 4,
    parameter int pSOURCES      = 8,
    parameter int pSELW         = 3,
    parameter int pSTRETCH_BITS = 20,
    parameter int pFLASH_BITS   = 22
) (
    input  logic                     usb_clk,
    input  logic                     reset_i,
    input  logic [pSOURCES-1:0]      I_src,
    input  logic [pLEDS*pSELW-1:0]   I_sel,
    input  logic [pLEDS*2-1:0]       I_mode,
    input  logic                     I_error,
    input  logic                     I_clear_error,
    input  logic                     I_error_en,
    output logic [pLEDS-1:0]         O_led,
    output logic                     O_error_latched
);

    logic [pSOURCES-1:0]    src_meta;
    logic [pSOURCES-1:0]    src_s;
    logic [pSOURCES-1:0]    src_d;
    logic [pSOURCES-1:0]    rise;
    logic                   err_meta;
    logic                   err_s;
    logic [pFLASH_BITS-1:0] flash_cnt;
    logic                   pattern;
    logic                   override;
    logic [pLEDS-1:0]       led_next;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            src_meta <= '0;
            src_s    <= '0;
            src_d    <= '0;
            err_meta <= 1'b0;
            err_s    <= 1'b0;
        end else begin
            src_meta <= I_src;
            src_s    <= src_meta;
            src_d    <= src_s;
            err_meta <= I_error;
            err_s    <= err_meta;
        end
    end

    assign rise = src_s & ~src_d;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            flash_cnt <= '0;
        end else begin
            flash_cnt <= flash_cnt + pFLASH_BITS'(1);
        end
    end

    assign pattern = flash_pattern(flash_cnt[pFLASH_BITS-1 -: 3]);

    // Set has priority so an error that is still present cannot be cleared.
    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            O_error_latched <= 1'b0;
        end else if (err_s) begin
            O_error_latched <= 1'b1;
        end else if (I_clear_error) begin
            O_error_latched <= 1'b0;
        end
    end

    assign override = O_error_latched & I_error_en;

    for (genvar n = 0; n < pLEDS; n++) begin : g_led
        logic [pSELW-1:0] sel;
        led_mode_e        mode;
        logic             src_n;
        logic             rise_n;
        logic             stretch_on;
        logic             led_n;

        assign sel  = I_sel[n*pSELW +: pSELW];
        assign mode = led_mode_e'(I_mode[n*2 +: 2]);

        // Explicit compare loop: indices at or above pSOURCES select nothing.
        always_comb begin
            src_n  = 1'b0;
            rise_n = 1'b0;
            for (int k = 0; k < pSOURCES; k++) begin
                if (sel == pSELW'(k)) begin
                    src_n  = src_s[k];
                    rise_n = rise[k];
                end
            end
        end

        // Keeps counting under the error override so the channel resumes
        // with the correct remaining on-time.
        led_stretch #(
            .pBITS (pSTRETCH_BITS)
        ) u_stretch (
            .usb_clk  (usb_clk),
            .reset_i  (reset_i),
            .I_trig   (rise_n),
            .I_enable (mode == LED_MODE_STRETCH),
            .O_on     (stretch_on)
        );

        always_comb begin
            led_n = 1'b0;
            case (mode)
                LED_MODE_DIRECT:  led_n = src_n;
                LED_MODE_STRETCH: led_n = stretch_on;
                LED_MODE_BLINK:   led_n = src_n & flash_cnt[pFLASH_BITS-1];
                default:          led_n = 1'b0;
            endcase
        end

        assign led_next[n] = led_n;
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            O_led <= '0;
        end else if (override) begin
            O_led <= {pLEDS{pattern}};
        end else begin
            O_led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl
// Scoreboard bench for led_status_ctrl with 4 LEDs, 6 sources,
// 16-cycle stretch and 64-cycle flash period. Expected values are pushed
// with the cycle at which they must appear and compared when that cycle
// is reached. Inputs change and outputs are sampled on the falling edge.
module tb_led_status_ctrl;
    import led_status_pkg::*;

    logic       usb_clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [5:0] I_src;
    logic [11:0] I_sel;
    logic [7:0] I_mode;
    logic       I_error;
    logic       I_clear_error;
    logic       I_error_en;
    logic [3:0] O_led;
    logic       O_error_latched;

    led_status_ctrl #(
        .pLEDS         (4),
        .pSOURCES      (6),
        .pSELW         (3),
        .pSTRETCH_BITS (4),
        .pFLASH_BITS   (6)
    ) dut (
        .usb_clk         (usb_clk),
        .reset_i         (reset_i),
        .I_src           (I_src),
        .I_sel           (I_sel),
        .I_mode          (I_mode),
        .I_error         (I_error),
        .I_clear_error   (I_clear_error),
        .I_error_en      (I_error_en),
        .O_led           (O_led),
        .O_error_latched (O_error_latched)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        int         due;
        bit         is_err;
        logic [3:0] mask;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         fc       = 0;
    logic [7:0] step_mask = 8'b0001_0101;

    // Reference free-running flash counter (64-cycle period).
    always @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) fc <= 0;
        else         fc <= (fc + 1) % 64;
    end

    function automatic logic pat(input int f);
        logic [2:0] st;
        st = 3'(f >> 3);
        return step_mask[st];
    endfunction

    task automatic push(input int due, input bit is_err, input logic [3:0] mask,
                        input logic [3:0] val, input string name);
        exp_t e;
        e.due = due; e.is_err = is_err; e.mask = mask; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    function automatic bit pop_due(output exp_t e);
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].due == cyc) begin
                e = sb[k];
                sb.delete(k);
                return 1'b1;
            end
        end
        e.due = 0; e.is_err = 1'b0; e.mask = 4'b0; e.val = 4'b0; e.name = "";
        return 1'b0;
    endfunction

    task automatic step();
        @(negedge usb_clk);
        cyc++;
    endtask

    task automatic set_led(input int n, input int sel, input logic [1:0] mode);
        I_sel[n*3 +: 3]  = 3'(sel);
        I_mode[n*2 +: 2] = mode;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] obs;
        int p;
        step();
        checks++;
        if (O_led !== 4'b0000) begin
            failures++; $display("FAIL reset_led got=%b want=0000", O_led);
        end
        checks++;
        if (O_error_latched !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b want=0", O_error_latched);
        end
        reset_i = 1'b0;
        set_led(0, 0, LED_MODE_STRETCH);
        repeat (3) step();
        p = cyc;
        I_src[0] = 1'b1;
        I_error  = 1'b1;
        for (int k = 3; k <= 9; k++) push(p + k, 1'b0, 4'b0001, 4'b0001, "rst_pre_on");
        push(p + 9, 1'b1, 4'b0000, 4'b0001, "rst_pre_err");
        for (int i = 0; i < 9; i++) begin
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == p + 1) I_src[0] = 1'b0;
        end
        // Stretch counter is at 9 here; reset must clear outputs without a clock edge.
        reset_i = 1'b1;
        I_error = 1'b0;
        #1;
        checks++;
        if (O_led !== 4'b0000) begin
            failures++; $display("FAIL midrst_led got=%b want=0000", O_led);
        end
        checks++;
        if (O_error_latched !== 1'b0) begin
            failures++; $display("FAIL midrst_err got=%b want=0", O_error_latched);
        end
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 25; i++) begin
            push(cyc + 1, 1'b0, 4'b1111, 4'b0000, "rst_after_led");
            push(cyc + 1, 1'b1, 4'b0000, 4'b0000, "rst_after_err");
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_direct();
        exp_t e;
        logic [3:0] obs;
        logic v;
        set_led(0, 0, LED_MODE_OFF);
        set_led(1, 2, LED_MODE_DIRECT);
        I_src = '0;
        repeat (4) step();
        for (int i = 0; i < 43; i++) begin
            if (i < 40) begin
                v = (i >= 5 && i <= 12) || (i == 20) || (i == 25) || (i == 26);
                I_src[2] = v;
                push(cyc + 3, 1'b0, 4'b0010, {2'b00, v, 1'b0}, "direct");
            end
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_stretch();
        exp_t e;
        logic [3:0] obs;
        int left;
        logic v;
        logic prev;
        logic [1:0] m;
        set_led(1, 0, LED_MODE_OFF);
        set_led(0, 0, LED_MODE_STRETCH);
        I_src = '0;
        repeat (4) step();
        left = 0;
        prev = 1'b0;
        for (int i = 0; i < 113; i++) begin
            if (i < 110) begin
                v = (i == 2) || (i == 30) || (i == 40) || (i >= 60 && i <= 65) || (i == 84);
                m = (i == 88 || i == 89) ? LED_MODE_OFF : LED_MODE_STRETCH;
                I_src[0] = v;
                set_led(0, 0, m);
                if (v && !prev) left = 16;
                if (m != LED_MODE_STRETCH) left = 0;
                // Mode switches act after one cycle, source edges after three;
                // the overlap window around the switch is not scored.
                if (i < 85 || i > 89) push(cyc + 3, 1'b0, 4'b0001, {3'b000, (left > 0)}, "stretch");
                if (left > 0) left--;
                prev = v;
            end
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [3:0] obs;
        logic [5:0] src;
        set_led(0, 0, LED_MODE_OFF);
        set_led(3, 0, LED_MODE_OFF);
        set_led(1, 5, LED_MODE_DIRECT);
        set_led(2, 7, LED_MODE_DIRECT);
        for (int i = 0; i < 43; i++) begin
            if (i < 40) begin
                src = (i < 20 || (i % 3) == 0) ? 6'h3F : 6'h00;
                if (i == 20) set_led(2, 6, LED_MODE_DIRECT);
                I_src = src;
                push(cyc + 3, 1'b0, 4'b0110, {2'b00, src[5], 1'b0}, "sel_range");
            end
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
        I_src = '0;
    endtask

    task automatic test_error_override();
        exp_t e;
        logic [3:0] obs;
        logic errv;
        for (int n = 0; n < 4; n++) set_led(n, n, LED_MODE_DIRECT);
        I_src = 6'b001111;
        repeat (4) step();
        for (int i = 0; i < 131; i++) begin
            if (i < 130) begin
                I_error       = (i < 90) || (i >= 110 && i < 120);
                I_clear_error = (i == 80) || (i == 100) || (i == 125);
                I_error_en    = (i < 110);
                errv = (i >= 2 && i <= 99) || (i >= 112 && i <= 124);
                push(cyc + 1, 1'b1, 4'b0000, {3'b000, errv}, "err_latch");
                if (i >= 3 && i <= 100) push(cyc + 1, 1'b0, 4'b1111, {4{pat(fc)}}, "override_pat");
                else                    push(cyc + 1, 1'b0, 4'b1111, 4'b1111, "err_normal");
            end
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
        I_error = 1'b0;
        I_clear_error = 1'b0;
    endtask

    task automatic test_blink();
        exp_t e;
        logic [3:0] obs;
        logic b;
        for (int n = 0; n < 3; n++) set_led(n, 0, LED_MODE_OFF);
        I_src = 6'b010000;
        repeat (4) step();
        set_led(3, 4, LED_MODE_BLINK);
        for (int i = 0; i < 221; i++) begin
            if (i < 220) begin
                if (i == 200) set_led(3, 4, LED_MODE_OFF);
                b = (i < 200) ? fc[5] : 1'b0;
                push(cyc + 1, 1'b0, 4'b1111, {b, 3'b000}, "blink");
            end
            step();
            while (pop_due(e)) begin
                checks++;
                obs = e.is_err ? {3'b000, O_error_latched} : (O_led & e.mask);
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        I_src         = '0;
        I_sel         = '0;
        I_mode        = 8'hFF;
        I_error       = 1'b0;
        I_clear_error = 1'b0;
        I_error_en    = 1'b0;
        #2 reset_i = 1'b1;
        test_reset();
        test_direct();
        test_stretch();
        test_out_of_range();
        test_error_override();
        test_blink();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
Parametrised front-panel LED / status-pin controller; generalises the fixed 4-LED arm/capturing/clock-alive/error-flash mux in the board top level.
- Drives pLEDS outputs, each independently routed from any of pSOURCES status inputs with a per-channel display mode.
- Includes input synchronisers, pulse stretching for short events, a latched error flag and a global error flash override.
- Sits in the top level between trace_top status outputs and the LED/header pins; configured from USB registers.

Parameters:
pLEDS, 4, number of LED outputs
pSOURCES, 8, number of selectable status inputs (min 2)
pSELW, 3, width of each per-LED source select field; must satisfy 2^pSELW >= pSOURCES
pSTRETCH_BITS, 20, stretch on-time = 2^pSTRETCH_BITS cycles
pFLASH_BITS, 22, error pattern period = 2^pFLASH_BITS cycles (min 4)

Ports:
usb_clk  input  1  sole clock
reset_i  input  1  asynchronous, active-high reset
I_src  input  pSOURCES  status levels/events; may be asynchronous to usb_clk
I_sel  input  pLEDS*pSELW  per-LED source index; LED n uses bits [n*pSELW +: pSELW]
I_mode  input  pLEDS*2  per-LED mode; LED n uses bits [n*2 +: 2]
I_error  input  1  error condition (level, asynchronous)
I_clear_error  input  1  single-cycle clear of latched error (usb_clk domain)
I_error_en  input  1  1 = error override allowed
O_led  output  pLEDS  registered LED drive
O_error_latched  output  1  latched error flag

Behaviour:
Reset:
- While reset_i is high: O_led=0, O_error_latched=0, all synchroniser flops, stretch counters and the flash counter = 0.
- Release is synchronous to the next usb_clk edge.

Synchronisers:
- Each I_src bit and I_error pass through a 2-flop synchroniser; s[k] is the synchronised value.
- An edge detector flop gives rise[k] = s[k] & ~s_d[k].

Source select:
- src_n = s[I_sel_n].
- rise_n = rise[I_sel_n].
- If I_sel_n >= pSOURCES: src_n=0 and rise_n=0.

Mode 0, DIRECT:
- led_n = src_n.
- Latency from an I_src change to O_led is 3 cycles: 2 synchroniser cycles plus 1 output register.

Mode 1, STRETCH:
- rise_n loads the channel counter with 2^pSTRETCH_BITS-1; the counter decrements to 0.
- led_n = (cnt != 0) | rise_n.
- A retrigger while cnt != 0 reloads the counter; there is no accumulation.
- Total on-time for a single isolated rise is exactly 2^pSTRETCH_BITS cycles.
- Changing mode away from STRETCH clears the counter.

Mode 2, BLINK:
- led_n = src_n & flash_cnt[pFLASH_BITS-1].
- This is a 50% blink while the source is high.

Mode 3, OFF:
- led_n = 0.

Flash counter:
- Free-running, pFLASH_BITS wide, wraps at 2^pFLASH_BITS-1 to 0.
- step = flash_cnt[pFLASH_BITS-1 -: 3].
- pattern = 1 for step 0, 2 and 4; 0 otherwise. This gives three blinks then a pause.

Error latch:
- Set when synchronised I_error = 1; cleared when I_clear_error = 1.
- If set and clear occur in the same cycle, set wins.
- O_error_latched is registered, 3 cycles after an I_error rise.

Override:
- If O_error_latched & I_error_en, then O_led[n] = pattern for every n, ignoring mode and select.
- Stretch counters keep running during override, so state is correct when the override ends.

Output:
- O_led[n] <= override ? pattern : led_n, registered.
- Select and mode changes take effect on the next cycle; there is no glitch filtering beyond the register.

Decomposition:
Package led_status_pkg:
- Mode constants: LED_MODE_DIRECT=2'd0, LED_MODE_STRETCH=2'd1, LED_MODE_BLINK=2'd2, LED_MODE_OFF=2'd3.
- Pattern step mask 8'b0001_0101.

Sub-module led_stretch, instantiated pLEDS times via generate:
- Parameter pBITS.
- Ports: usb_clk, reset_i, I_trig, I_enable, O_on.
- Contains the reload/decrement counter.

Flash counter, synchronisers and error latch remain in the parent.

Test Plan:
All scenarios use pSTRETCH_BITS=4 and pFLASH_BITS=6.
1. Reset mid-operation: LED0 in STRETCH with cnt=9, assert reset_i for 1 cycle -> O_led=0 and O_error_latched=0 immediately, without waiting for a clock; after release, LED0 stays 0 until the next source rise.
2. DIRECT latency: LED1 sel=2, mode=0; toggle I_src[2] 0->1 at cycle t -> O_led[1]=1 first at t+3, and returns to 0 at t'+3 after I_src[2] falls at t'.
3. STRETCH length and retrigger:
   - LED0 sel=0, mode=1; a 1-cycle pulse on I_src[0] -> O_led[0] high for exactly 16 cycles.
   - A second pulse 10 cycles after the first -> high for 26 cycles total.
4. Out-of-range select: pSOURCES=6, LED2 sel=7 with DIRECT mode and all I_src=1 -> O_led[2]=0 permanently.
5. Error override and clear:
   - Raise I_error with I_error_en=1 -> O_error_latched=1 at +3; all O_led follow the 101010 00 step pattern (8-cycle steps, 64-cycle period).
   - I_clear_error while I_error is still 1 -> the latch stays 1 (set wins).
   - Drop I_error, then clear -> normal modes resume next cycle.
6. BLINK with the flash counter wrapping: LED3 mode=2, I_src selected high -> O_led[3] is 32 cycles off / 32 cycles on, phase-aligned to flash_cnt bit 5 (offset by the output register) across 3 wraps; mode=3 -> constant 0.
